// File: rtl/precision_grant_scheduler_pkg.sv
// precision_pkg
// Shared types, constants and helper functions for precision_grant_scheduler.
//   - Precision codes PREC_HIGH (0) .. PREC_MINIMAL (5); codes 6 and 7 are
//     treated as PREC_MINIMAL.
//   - Field widths: PREC_W (precision code), CLA_W (adder result), TRUNC_W
//     (truncated output).
//   - clamp_sel   : folds out-of-range codes onto PREC_MINIMAL.
//   - prec_cost   : budget tokens consumed by a grant at a given code.
//   - trunc_slice : picks the 7-bit window of the adder result for a code.
package precision_pkg;

    localparam int PREC_W  = 3;
    localparam int CLA_W   = 12;
    localparam int TRUNC_W = 7;

    localparam logic [PREC_W-1:0] PREC_HIGH    = 3'd0;
    localparam logic [PREC_W-1:0] PREC_FINE    = 3'd1;
    localparam logic [PREC_W-1:0] PREC_MEDIUM  = 3'd2;
    localparam logic [PREC_W-1:0] PREC_COARSE  = 3'd3;
    localparam logic [PREC_W-1:0] PREC_LOW     = 3'd4;
    localparam logic [PREC_W-1:0] PREC_MINIMAL = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } sched_state_t;

    // Codes above the coarsest legal precision behave as the coarsest one.
    function automatic logic [PREC_W-1:0] clamp_sel(input logic [PREC_W-1:0] sel);
        return (sel > PREC_MINIMAL) ? PREC_MINIMAL : sel;
    endfunction

    // Finer precision costs more energy; the coarsest code is free.
    function automatic logic [PREC_W-1:0] prec_cost(input logic [PREC_W-1:0] sel);
        return PREC_MINIMAL - sel;
    endfunction

    // Window slides one bit toward the LSB for each step of coarser code.
    function automatic logic [TRUNC_W-1:0] trunc_slice(input logic [CLA_W-1:0] data,
                                                       input logic [PREC_W-1:0] sel);
        logic [TRUNC_W-1:0] slice;
        case (sel)
            PREC_HIGH:   slice = data[11:5];
            PREC_FINE:   slice = data[10:4];
            PREC_MEDIUM: slice = data[9:3];
            PREC_COARSE: slice = data[8:2];
            PREC_LOW:    slice = data[7:1];
            default:     slice = data[6:0];
        endcase
        return slice;
    endfunction

endpackage

// File: rtl/precision_grant_scheduler_if.sv
// precision_grant_scheduler_if
// Bundles the requester side and the result side of the scheduler.
//   req_valid/req_ready : per-requester handshake (N_REQ bits each)
//   req_data            : packed 12-bit adder results, requester i at [12i+11:12i]
//   req_sel             : packed 3-bit precision codes, requester i at [3i+2:3i]
//   out_valid/out_ready : result handshake
//   out_result          : 7-bit truncated result
//   out_id              : index of the requester that produced out_result
//   out_sel             : precision code actually applied
//   budget_level        : current energy budget token count
// Modports: slave for the scheduler, master for whatever drives it.
interface precision_grant_scheduler_if
    import precision_pkg::*;
#(
    parameter int N_REQ = 4
);

    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*CLA_W-1:0]  req_data;
    logic [N_REQ*PREC_W-1:0] req_sel;
    logic                    out_valid;
    logic                    out_ready;
    logic [TRUNC_W-1:0]      out_result;
    logic [ID_W-1:0]         out_id;
    logic [PREC_W-1:0]       out_sel;
    logic [7:0]              budget_level;

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_sel,
        input  out_ready,
        output req_ready,
        output out_valid,
        output out_result,
        output out_id,
        output out_sel,
        output budget_level
    );

    modport master (
        output req_valid,
        output req_data,
        output req_sel,
        output out_ready,
        input  req_ready,
        input  out_valid,
        input  out_result,
        input  out_id,
        input  out_sel,
        input  budget_level
    );

endinterface

// File: rtl/precision_grant_scheduler_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. Searches the request vector starting one
// position above rr_ptr, wrapping, and grants the first set bit.
//   req       : request vector
//   rr_ptr    : index of the previous winner
//   en        : when low no grant is issued
//   grant     : one-hot grant (all zero when nothing granted)
//   grant_idx : encoded index of the granted requester (0 when none)
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    input  logic                     en,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(N_REQ);

    // Position `step` places after base, modulo N_REQ. base < N_REQ and
    // step <= N_REQ, so one conditional subtraction is enough.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int step);
        int pos;
        pos = int'(base) + step;
        if (pos >= N_REQ) begin
            pos = pos - N_REQ;
        end
        return IDX_W'(pos);
    endfunction

    logic found;

    // Priority scan beginning just above the last winner; rr_ptr itself is
    // visited last so a lone requester can still win repeatedly.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int step = 1; step <= N_REQ; step++) begin
            if (en && !found && req[wrap_idx(rr_ptr, step)]) begin
                grant[wrap_idx(rr_ptr, step)] = 1'b1;
                grant_idx                     = wrap_idx(rr_ptr, step);
                found                         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/precision_grant_scheduler.sv
// precision_grant_scheduler
// Shares one registered truncation stage between N_REQ requesters. A
// round-robin arbiter picks a requester, its 12-bit adder result is cut to 7
// bits at the requested precision, and the result is returned with the
// requester index and the precision code applied.
//
// Optional feature macro: PRECISION_BUDGET_EN
//   defined   - energy budget tracker with periodic refill; grants are
//               degraded to coarser precision when the budget runs low.
//   undefined - no budget logic; budget_level is tied to BUDGET_MAX.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : precision_grant_scheduler_if.slave (requester and result sides)
module precision_grant_scheduler
    import precision_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int BUDGET_MAX    = 255,
    parameter int REFILL_PERIOD = 16,
    parameter int REFILL_AMOUNT = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    precision_grant_scheduler_if.slave  bus
);

    localparam int ID_W = $clog2(N_REQ);

    sched_state_t       state;
    logic               can_accept;
    logic               arb_en;
    logic               grant_any;
    logic [N_REQ-1:0]   grant;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    rr_ptr;

    logic [CLA_W-1:0]   data_arr [N_REQ];
    logic [PREC_W-1:0]  sel_arr  [N_REQ];
    logic [CLA_W-1:0]   win_data;
    logic [PREC_W-1:0]  win_sel;
    logic [PREC_W-1:0]  eff_sel;

    logic               out_valid_q;
    logic [TRUNC_W-1:0] out_result_q;
    logic [ID_W-1:0]    out_id_q;
    logic [PREC_W-1:0]  out_sel_q;

    // Unpack the flat request buses; codes are clamped here so nothing
    // downstream ever sees 6 or 7.
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign data_arr[i] = bus.req_data[i*CLA_W +: CLA_W];
        assign sel_arr[i]  = clamp_sel(bus.req_sel[i*PREC_W +: PREC_W]);
    end

    // A new grant is possible when idle, or when the held result is being
    // taken this cycle. rst_n is folded in so req_ready stays low while reset
    // is asserted even if requesters are already presenting.
    assign can_accept = (state == ST_IDLE) || bus.out_ready;
    assign arb_en     = can_accept && rst_n;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arbiter (
        .req       (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign grant_any     = |grant;
    assign bus.req_ready = grant;
    assign win_data      = data_arr[grant_idx];
    assign win_sel       = sel_arr[grant_idx];

`ifdef PRECISION_BUDGET_EN
    localparam int RC_W = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;

    logic [RC_W-1:0]   refill_cnt;
    logic              refill;
    logic [7:0]        budget_q;
    logic [7:0]        budget_d;
    logic [9:0]        budget_sum;
    logic [PREC_W-1:0] floor_sel;

    assign refill = (refill_cnt == RC_W'(REFILL_PERIOD - 1));

    // With fewer than 5 tokens left the finest affordable code is 5-budget;
    // raising the request to at least that code keeps the cost within the
    // remaining budget, so the subtraction below can never underflow.
    always_comb begin
        floor_sel = PREC_HIGH;
        eff_sel   = win_sel;
        if (budget_q < 8'd5) begin
            floor_sel = PREC_W'(8'd5 - budget_q);
            if (win_sel < floor_sel) begin
                eff_sel = floor_sel;
            end
        end
    end

    // Grant cost and refill credit land in one saturating update, so a
    // grant and a refill on the same edge are both honoured.
    always_comb begin
        budget_sum = {2'b00, budget_q};
        if (grant_any) begin
            budget_sum = budget_sum - {7'd0, prec_cost(eff_sel)};
        end
        if (refill) begin
            budget_sum = budget_sum + 10'(REFILL_AMOUNT);
        end
        if (budget_sum > 10'(BUDGET_MAX)) begin
            budget_sum = 10'(BUDGET_MAX);
        end
        budget_d = 8'(budget_sum);
    end

    // Free-running refill timer and the budget register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refill_cnt <= '0;
            budget_q   <= 8'(BUDGET_MAX);
        end else begin
            refill_cnt <= refill ? '0 : refill_cnt + 1'b1;
            budget_q   <= budget_d;
        end
    end

    assign bus.budget_level = budget_q;
`else
    assign eff_sel          = win_sel;
    assign bus.budget_level = 8'(BUDGET_MAX);
`endif

    // Control FSM with registered outputs. Once BUSY the output registers
    // only change when the current result is accepted, which is what gives
    // a stable hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_id_q     <= '0;
            out_sel_q    <= '0;
            rr_ptr       <= ID_W'(N_REQ - 1);
        end else if (can_accept) begin
            if (grant_any) begin
                state        <= ST_BUSY;
                out_valid_q  <= 1'b1;
                out_result_q <= trunc_slice(win_data, eff_sel);
                out_id_q     <= grant_idx;
                out_sel_q    <= eff_sel;
                rr_ptr       <= grant_idx;
            end else begin
                state        <= ST_IDLE;
                out_valid_q  <= 1'b0;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_id     = out_id_q;
    assign bus.out_sel    = out_sel_q;

endmodule
